// File: rtl/mem_responder_if.sv
// Request/response channel between a cache miss path (master) and the data memory (slave).
// Read and write each use their own valid/ready four-phase handshake.
interface mem_responder_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 read_valid;
    logic [ADDR_BITS-1:0] read_address;
    logic                 read_ready;
    logic [DATA_BITS-1:0] read_data;
    logic                 write_valid;
    logic [ADDR_BITS-1:0] write_address;
    logic [DATA_BITS-1:0] write_data;
    logic                 write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Single-channel memory responder: one read or write at a time from an internal word array.
// Latency: ready rises READ_LATENCY/WRITE_LATENCY edges after accept; held until valid drops.
// Backpressure: one outstanding request; MEM_RESP_STATS_EN adds saturating completion counters.
module mem_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    output logic [15:0]       read_count,
    output logic [15:0]       write_count
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [15:0] RD_LOAD = 16'(READ_LATENCY - 1);
    localparam logic [15:0] WR_LOAD = 16'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RD_RESP,
        WR_RESP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [15:0]          lat_cnt;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_data;
    logic [DATA_BITS-1:0] rd_buf;
    logic [DATA_BITS-1:0] mem [DEPTH];

    logic                 read_ready_q;
    logic                 write_ready_q;
    logic [DATA_BITS-1:0] read_data_q;

    logic accept_rd;
    logic accept_wr;
    logic rd_done;
    logic wr_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        rd_done   = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: begin
                // Read has priority; a concurrent write stays pending on its held valid.
                if (bus.read_valid) begin
                    accept_rd = 1'b1;
                    state_nxt = RD_WAIT;
                end else if (bus.write_valid) begin
                    accept_wr = 1'b1;
                    state_nxt = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == 16'd0) begin
                    rd_done   = 1'b1;
                    state_nxt = RD_RESP;
                end
            end
            WR_WAIT: begin
                if (lat_cnt == 16'd0) begin
                    wr_done   = 1'b1;
                    state_nxt = WR_RESP;
                end
            end
            RD_RESP: begin
                if (!bus.read_valid) state_nxt = IDLE;
            end
            WR_RESP: begin
                if (!bus.write_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt  <= '0;
            req_addr <= '0;
            req_data <= '0;
            rd_buf   <= '0;
        end else if (accept_rd) begin
            lat_cnt  <= RD_LOAD;
            req_addr <= bus.read_address;
            rd_buf   <= mem[bus.read_address];
        end else if (accept_wr) begin
            lat_cnt  <= WR_LOAD;
            req_addr <= bus.write_address;
            req_data <= bus.write_data;
        end else if ((state == RD_WAIT || state == WR_WAIT) && lat_cnt != 16'd0) begin
            lat_cnt <= lat_cnt - 16'd1;
        end
    end

    // Write commits on leaving WR_WAIT, so a following read always sees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_done) begin
            mem[req_addr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            read_data_q   <= '0;
        end else begin
            read_ready_q  <= rd_done || (state == RD_RESP && bus.read_valid);
            write_ready_q <= wr_done || (state == WR_RESP && bus.write_valid);
            if (rd_done) read_data_q <= rd_buf;
        end
    end

    assign bus.read_ready  = read_ready_q;
    assign bus.write_ready = write_ready_q;
    assign bus.read_data   = read_data_q;

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (rd_done && read_count != 16'hFFFF)  read_count  <= read_count + 16'd1;
            if (wr_done && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
        end
    end
`else
    assign read_count  = 16'd0;
    assign write_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table of reads/writes plus multi-cycle corner sequences.
module tb_mem_responder;

    localparam int RL = 2;
    localparam int WL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] read_count;
    logic [15:0] write_count;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8)) bus ();

    mem_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .read_count(read_count),
        .write_count(write_count)
    );

    int checks   = 0;
    int failures = 0;
    int exp_rd   = 0;
    int exp_wr   = 0;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.read_ready === 1'b1 && bus.write_ready === 1'b1) begin
            check("one_ready", 32'd1, 32'd0);
        end
    end

    task automatic wait_ready(input bit is_rd, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(is_rd ? bus.read_ready : bus.write_ready) && cyc < 50);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        int cyc;
        bus.write_valid   = 1'b1;
        bus.write_address = addr;
        bus.write_data    = data;
        wait_ready(1'b0, cyc);
        check("wr_latency", cyc, WL + 1);
        check("wr_rd_ready_low", bus.read_ready, 1'b0);
        bus.write_address = ~addr;
        bus.write_data    = ~data;
        @(negedge clk);
        check("wr_hold", bus.write_ready, 1'b1);
        bus.write_valid = 1'b0;
        @(negedge clk);
        check("wr_clear", bus.write_ready, 1'b0);
        exp_wr++;
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] exp);
        int cyc;
        bus.read_valid   = 1'b1;
        bus.read_address = addr;
        wait_ready(1'b1, cyc);
        check("rd_latency", cyc, RL + 1);
        check("rd_data", bus.read_data, exp);
        bus.read_address = ~addr;
        @(negedge clk);
        check("rd_hold", {bus.read_ready, bus.read_data}, {1'b1, exp});
        bus.read_valid = 1'b0;
        @(negedge clk);
        check("rd_clear", {bus.read_ready, bus.read_data}, {1'b0, exp});
        exp_rd++;
    endtask

    task automatic check_counts(input string name);
`ifdef MEM_RESP_STATS_EN
        check(name, {read_count, write_count}, {16'(exp_rd), 16'(exp_wr)});
`else
        check(name, {read_count, write_count}, 32'd0);
`endif
    endtask

    initial begin
        int cyc;
        int pulses;
        int bad;

        vecs[0] = '{1'b1, 8'h05, 8'hA5};
        vecs[1] = '{1'b0, 8'h05, 8'hA5};
        vecs[2] = '{1'b0, 8'h7F, 8'h00};
        vecs[3] = '{1'b1, 8'hFF, 8'h5A};
        vecs[4] = '{1'b0, 8'hFF, 8'h5A};
        vecs[5] = '{1'b1, 8'h00, 8'h11};
        vecs[6] = '{1'b0, 8'h00, 8'h11};
        vecs[7] = '{1'b1, 8'h05, 8'hC3};
        vecs[8] = '{1'b0, 8'h05, 8'hC3};

        reset             = 1'b1;
        bus.read_valid    = 1'b0;
        bus.read_address  = '0;
        bus.write_valid   = 1'b0;
        bus.write_address = '0;
        bus.write_data    = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.read_ready, bus.write_ready, bus.read_data}, 10'd0);
        check("reset_counts", {read_count, write_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].data);
        end
        check_counts("counts_table");

        // Simultaneous request: read of old contents first, then the pending write.
        bus.read_valid    = 1'b1;
        bus.read_address  = 8'h10;
        bus.write_valid   = 1'b1;
        bus.write_address = 8'h10;
        bus.write_data    = 8'h3C;
        wait_ready(1'b1, cyc);
        check("both_rd_latency", cyc, RL + 1);
        check("both_rd_data", bus.read_data, 8'h00);
        check("both_wr_waiting", bus.write_ready, 1'b0);
        bus.read_valid = 1'b0;
        exp_rd++;
        wait_ready(1'b0, cyc);
        check("both_wr_latency", cyc, WL + 2);
        bus.write_valid = 1'b0;
        @(negedge clk);
        check("both_wr_clear", bus.write_ready, 1'b0);
        exp_wr++;
        do_read(8'h10, 8'h3C);

        // Write valid dropped right after accept: still commits, ready pulses once.
        bus.write_valid   = 1'b1;
        bus.write_address = 8'h20;
        bus.write_data    = 8'h77;
        @(negedge clk);
        bus.write_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.write_ready) pulses++;
        end
        check("abort_wr_pulse", pulses, 1);
        exp_wr++;
        do_read(8'h20, 8'h77);
        check_counts("counts_mid");

        // Reset during RD_WAIT aborts the read and clears the array.
        bus.read_valid   = 1'b1;
        bus.read_address = 8'h05;
        @(negedge clk);
        reset          = 1'b1;
        bus.read_valid = 1'b0;
        @(negedge clk);
        check("rst_wait_ready", bus.read_ready, 1'b0);
        check("rst_wait_counts", {read_count, write_count}, 32'd0);
        reset = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.read_ready) bad++;
        end
        check("rst_no_ready", bad, 0);
        do_read(8'h05, 8'h00);

        do_write(8'h30, 8'h09);
        do_write(8'h31, 8'h08);
        do_read(8'h30, 8'h09);
        do_read(8'h31, 8'h08);
        check_counts("counts_3r_2w");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
